// File: rtl/pool_unit_arbiter.sv
// Round-robin front end that time-shares one 2x2 average-pooling unit among
// NUM_REQ requesters: grant, clear unit, stream 4 pixels, wait, return tagged result.
module pool_unit_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int POOL_LAT = 4,
  parameter int ID_W     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*4*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ID_W-1:0]             resp_id,
  output logic signed [DATA_W-1:0]    resp_data,
  output logic                        busy,
  output logic signed [DATA_W-1:0]    pu_data,
  output logic                        pu_en,
  output logic                        pu_rst,
  input  logic signed [DATA_W-1:0]    pu_avg
);

  localparam int LAT_W = $clog2(POOL_LAT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, RESP} state_t;
  typedef logic [3:0][DATA_W-1:0] win_t;

  state_t state, state_nxt;

  logic [NUM_REQ-1:0][3:0][DATA_W-1:0] req_win;
  win_t                win, gnt_win;
  logic [ID_W-1:0]     last_grant, cur_id, gnt_id;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic                found, hs;
  logic [1:0]          feed_cnt;
  logic [LAT_W-1:0]    lat_cnt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_win[g] = req_data[g*4*DATA_W +: 4*DATA_W];
  end

  // Two passes: requesters above last_grant first, then wrap to the rest.
  always_comb begin
    gnt_oh  = '0;
    gnt_id  = '0;
    gnt_win = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && i > int'(last_grant)) begin
        found     = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_id    = ID_W'(i);
        gnt_win   = req_win[i];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && i <= int'(last_grant)) begin
        found     = 1'b1;
        gnt_oh[i] = 1'b1;
        gnt_id    = ID_W'(i);
        gnt_win   = req_win[i];
      end
    end
  end

  // Gated by rst so no grant can slip through in a reset cycle.
  assign req_ready = (state == IDLE && !rst) ? gnt_oh : '0;
  assign hs        = |req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (hs) state_nxt = CLEAR;
      CLEAR: state_nxt = FEED;
      FEED:  if (feed_cnt == 2'd3) state_nxt = WAIT;
      WAIT:  if (lat_cnt == LAT_W'(POOL_LAT)) state_nxt = RESP;
      RESP:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pu_rst resets high so the shared unit stays cleared while rst is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      win        <= '0;
      feed_cnt   <= '0;
      lat_cnt    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      busy       <= 1'b0;
      pu_data    <= '0;
      pu_en      <= 1'b0;
      pu_rst     <= 1'b1;
    end else begin
      pu_rst <= 1'b0;
      busy   <= (state_nxt != IDLE);
      case (state)
        IDLE: if (hs) begin
          win        <= gnt_win;
          cur_id     <= gnt_id;
          last_grant <= gnt_id;
          feed_cnt   <= '0;
          pu_rst     <= 1'b1;
          pu_en      <= 1'b0;
        end
        CLEAR: begin
          pu_en   <= 1'b1;
          pu_data <= win[0];
        end
        FEED: if (feed_cnt == 2'd3) begin
          pu_en   <= 1'b0;
          lat_cnt <= LAT_W'(1);
        end else begin
          feed_cnt <= feed_cnt + 2'd1;
          pu_data  <= win[feed_cnt + 2'd1];
        end
        WAIT: if (lat_cnt == LAT_W'(POOL_LAT)) begin
          resp_data  <= pu_avg;
          resp_id    <= cur_id;
          resp_valid <= 1'b1;
        end else begin
          lat_cnt <= lat_cnt + LAT_W'(1);
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_unit_arbiter.sv
// Directed bench for pool_unit_arbiter with a behavioural pooling unit and
// a grant/response scoreboard checked on every handshake.
module tb_pool_unit_arbiter;
  localparam int NUM_REQ = 4, DATA_W = 32, POOL_LAT = 4, ID_W = 3;

  logic clk = 1'b0, rst = 1'b1;
  logic [NUM_REQ-1:0]          req_valid = '0;
  logic [NUM_REQ*4*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        resp_valid, resp_ready = 1'b1;
  logic [ID_W-1:0]             resp_id;
  logic signed [DATA_W-1:0]    resp_data, pu_data, pu_avg;
  logic                        busy, pu_en, pu_rst;

  logic signed [31:0] win [NUM_REQ][4];

  always #5 clk = ~clk;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    for (genvar k = 0; k < 4; k++) begin : g_w
      assign req_data[i*4*DATA_W + k*DATA_W +: DATA_W] = win[i][k];
    end
  end

  pool_unit_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .POOL_LAT(POOL_LAT), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .pu_data(pu_data), .pu_en(pu_en), .pu_rst(pu_rst), .pu_avg(pu_avg));

  // Pooling unit: accumulate on enable, show sum>>>2 only POOL_LAT cycles after the last enable.
  logic signed [DATA_W+2:0] acc = '0;
  int since = 0;
  always @(posedge clk) begin
    if (pu_rst) begin
      acc   <= '0;
      since <= 0;
    end else if (pu_en) begin
      acc   <= acc + pu_data;
      since <= 1;
    end else if (since > 0 && since < 100) begin
      since <= since + 1;
    end
  end
  assign pu_avg = (since >= POOL_LAT) ? DATA_W'(acc >>> 2) : 32'sh5EAD_BEEF;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic signed [31:0] data; } exp_t;
  int   grant_q [$];
  exp_t resp_q  [$];
  int   tests = 0, fails = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic signed [31:0] avg4(input int i);
    longint s;
    s = longint'(win[i][0]) + longint'(win[i][1]) + longint'(win[i][2]) + longint'(win[i][3]);
    s = s >>> 2;
    return 32'(s);
  endfunction

  task automatic push(input int id, input logic signed [31:0] data);
    exp_t r;
    r.id = id;
    r.data = data;
    grant_q.push_back(id);
    resp_q.push_back(r);
  endtask

  // Monitor: grants, response contents/latency, pu_rst/pu_en framing.
  int   hs_c = 0, resp_cnt = 0, en_run = 0, e;
  exp_t r;
  logic prev_rst = 1'b0, prev_rv = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst && |(req_valid & req_ready)) begin
      hs_c = cyc;
      if (grant_q.size() == 0) chk("unexpected grant", longint'(req_ready), 0);
      else begin
        e = grant_q.pop_front();
        chk("grant", longint'(req_ready), longint'(1) << e);
      end
    end
    if (resp_valid && !prev_rv) chk("resp latency", cyc - hs_c, 6 + POOL_LAT);
    if (resp_valid && resp_ready) begin
      if (resp_q.size() == 0) chk("unexpected resp", longint'(resp_valid), 0);
      else begin
        r = resp_q.pop_front();
        chk("resp_id", longint'(resp_id), r.id);
        chk("resp_data", resp_data, r.data);
      end
      resp_cnt++;
    end
    if (rst) en_run = 0;
    else if (pu_en) begin
      if (en_run == 0) chk("pu_rst before feed", longint'(prev_rst), 1);
      en_run++;
    end else if (en_run != 0) begin
      chk("pu_en run length", en_run, 4);
      en_run = 0;
    end
    prev_rst = pu_rst;
    prev_rv  = resp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int i, input int a, input int b, input int c, input int d);
    win[i][0] = a; win[i][1] = b; win[i][2] = c; win[i][3] = d;
  endtask

  // Returns just after the handshake edge.
  task automatic wait_grant(input int idx);
    for (int n = 0; n < 100; n++) begin
      #1;
      if (req_ready[idx]) begin
        step();
        return;
      end
      step();
    end
    chk("grant timeout", longint'(req_ready[idx]), 1);
  endtask

  task automatic wait_resp(input int target);
    for (int n = 0; n < 200; n++) begin
      if (resp_cnt >= target) return;
      step();
    end
    chk("resp timeout", resp_cnt, target);
  endtask

  task automatic chk_reset();
    chk("rst req_ready", longint'(req_ready), 0);
    chk("rst resp_valid", longint'(resp_valid), 0);
    chk("rst resp_id", longint'(resp_id), 0);
    chk("rst resp_data", resp_data, 0);
    chk("rst busy", longint'(busy), 0);
    chk("rst pu_data", pu_data, 0);
    chk("rst pu_en", longint'(pu_en), 0);
    chk("rst pu_rst", longint'(pu_rst), 1);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) set_win(i, 0, 0, 0, 0);
    rst = 1'b1;
    req_valid = '1;
    repeat (3) step();
    chk_reset();

    // Fairness: all held high, expect 0,1,2,3,0
    set_win(0, 1, 2, 3, 4);
    set_win(1, 100, -20, 7, 9);
    set_win(2, -1, -1, -1, -2);
    set_win(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    push(0, avg4(0)); push(1, avg4(1)); push(2, avg4(2)); push(3, avg4(3)); push(0, avg4(0));
    req_valid = 4'hF;
    rst = 1'b0;
    wait_resp(5);
    req_valid = '0;

    // Single request
    set_win(0, 4, 8, 12, 16);
    push(0, 10);
    req_valid = 4'b0001;
    wait_grant(0);
    req_valid = '0;
    chk("clear busy", longint'(busy), 1);
    chk("clear pu_rst", longint'(pu_rst), 1);
    chk("clear pu_en", longint'(pu_en), 0);
    wait_resp(6);
    chk("idle busy", longint'(busy), 0);
    chk("idle resp_valid", longint'(resp_valid), 0);

    // Negative values
    set_win(2, -4, -8, -12, -16);
    push(2, -10);
    req_valid = 4'b0100;
    wait_grant(2);
    req_valid = '0;
    wait_resp(7);

    // Backpressure, with req 0 waiting behind it
    set_win(1, 40, -40, 13, 3);
    push(1, 4);
    push(0, 10);
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    wait_grant(1);
    req_valid = 4'b0001;
    for (int n = 0; n < 50 && !resp_valid; n++) step();
    chk("bp resp_valid", longint'(resp_valid), 1);
    repeat (5) begin
      chk("bp resp_id", longint'(resp_id), 1);
      chk("bp resp_data", resp_data, 4);
      chk("bp req_ready", longint'(req_ready), 0);
      step();
    end
    resp_ready = 1'b1;
    step();
    chk("grant after release", longint'(req_ready), 1);
    wait_grant(0);
    req_valid = '0;
    wait_resp(9);

    // Data change after grant
    set_win(1, 8, 8, 8, 8);
    push(1, 8);
    req_valid = 4'b0010;
    wait_grant(1);
    req_valid = '0;
    step();
    set_win(1, -100, -100, -100, -100);
    wait_resp(10);

    // Reset during FEED, then req 3 alone
    set_win(2, 5, 5, 5, 5);
    grant_q.push_back(2);
    req_valid = 4'b0100;
    wait_grant(2);
    req_valid = '0;
    step();
    step();
    chk("feed pu_en", longint'(pu_en), 1);
    rst = 1'b1;
    step();
    set_win(3, 20, 21, 22, 23);
    req_valid = 4'b1000;
    #1;
    chk_reset();
    push(3, 21);
    rst = 1'b0;
    wait_grant(3);
    req_valid = '0;
    wait_resp(11);

    // Requester 0 back on top
    push(0, 10);
    req_valid = 4'hF;
    wait_grant(0);
    req_valid = '0;
    wait_resp(12);

    repeat (3) step();
    chk("grant_q drained", grant_q.size(), 0);
    chk("resp_q drained", resp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
